demux_12: RTL and testbench
===========================

Name: demux_12

Overview:
- Registered 1:2 time-slot demultiplexer: the receive-side inverse of the 2:1 mux.
- Takes one serial lane in which lane-0 and lane-1 data alternate every HOLD clocks, as produced by a mux whose selector toggles every HOLD cycles.
- Separates the stream back into two registered outputs and presents each completed pair with a one-cycle valid strobe.
- Sits after the mux in the same bench/datapath so the round trip mux -> demux can be checked end to end.

Parameters:
- WIDTH, 1: bit width of data_in, data_0, data_1.
- HOLD, 2: clocks per lane slot. Must be >= 1. Slot counter width is max(1, clog2(HOLD)).
- CNT_W, 8: width of pair_count.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- reset  input  1  synchronous, active-high reset.
- sync  input  1  one-cycle pulse marking the first cycle of a lane-0 slot; (re)aligns slot phase.
- enable  input  1  when low, slot counter and state freeze; outputs hold.
- data_in  input  WIDTH  multiplexed stream.
- selector  output  1  lane currently being received (0 in IDLE/LANE0, 1 in LANE1), registered.
- data_0  output  WIDTH  last completed lane-0 sample.
- data_1  output  WIDTH  last completed lane-1 sample.
- valid_out  output  1  one-cycle strobe: data_0/data_1 updated with a new pair.
- pair_count  output  CNT_W  number of pairs delivered since reset, wraps.

Behaviour:
- Reset (sampled on posedge clk with reset=1): state=IDLE, slot counter=0, shadow register=0. selector, data_0, data_1, valid_out and pair_count all 0. Reset overrides every other input.
- States: IDLE, LANE0, LANE1.
- IDLE: ignore data_in and enable. sync=1 -> LANE0 with counter=0; that same sync cycle is slot cycle 0 of lane 0.
- LANE0, enable=1:
  - counter increments each clock.
  - When counter==HOLD-1, capture data_in into shadow, reset counter to 0, go to LANE1, selector<=1.
- LANE1, enable=1:
  - When counter==HOLD-1: data_1<=data_in, data_0<=shadow, valid_out<=1 for the next cycle only, pair_count<=pair_count+1 (wraps 2^CNT_W-1 -> 0), counter<=0, go to LANE0, selector<=0.
- Sampling uses the last cycle of each slot, so data is taken after the upstream selector has settled.
- Latency: valid_out rises 1 clock after the final lane-1 slot cycle, i.e. 2*HOLD clocks after the sync cycle for the first pair.
- enable=0: counter, state, shadow and selector hold. valid_out is forced 0. Slot cycles are counted only on enable=1 clocks.
- sync while in LANE0/LANE1 (mid-frame): go to LANE0 with counter=0, discard shadow (cleared to 0). No valid_out for the partial pair. data_0/data_1/pair_count hold.
  - sync has priority over enable=0 and over a coinciding slot-end capture; that cycle counts as lane-0 slot cycle 0.
- HOLD=1: every enabled clock alternates lanes; a pair completes every 2 enabled clocks.
- data_0/data_1 change only on valid_out cycles; between strobes they hold.

Decomposition:
- Shared package demux_pkg:
  - state encoding localparams ST_IDLE=2'd0, ST_LANE0=2'd1, ST_LANE1=2'd2 (unused code 2'd3 returns to IDLE);
  - default HOLD and CNT_W constants, reused by the bench.
- One natural sub-module: slot_counter. It takes the HOLD parameter and inputs clk, reset, clear, enable, and outputs slot_end. It is instantiated once; the FSM and data registers stay in demux_12.

Test Plan:
- Reset: hold reset 3 clocks with data_in=1, sync=1 -> all outputs 0, state IDLE, no valid_out.
- Basic pair (HOLD=2, WIDTH=1): sync at cycle 0, enable=1, data_in=0 for cycles 0-1 and 1 for cycles 2-3 -> cycle 4: valid_out=1, data_0=0, data_1=1, pair_count=1; selector 0,0,1,1,0.
- Stream of 4 pairs alternating (0,1),(1,0),(0,1),(1,0) -> 4 strobes spaced 4 clocks apart, outputs match each pair, pair_count=4.
- Enable stall: deassert enable for 3 clocks during LANE1 slot cycle 0 -> strobe delayed exactly 3 clocks, values unchanged, valid_out never high while enable=0.
- Mid-frame sync: sync asserted on LANE1 slot cycle 0 -> no strobe for the partial pair; the next strobe arrives 4 clocks after that sync with the new pair.
- Wrap and HOLD=1: CNT_W=2, HOLD=1, run 5 pairs -> pair_count sequence 1,2,3,0,1, with a strobe every 2 clocks.

Source files
------------

// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared state encoding and defaults for the 1:2 time-slot demux
package demux_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_LANE0 = 2'd1;
  localparam state_t ST_LANE1 = 2'd2;

  localparam int DEF_HOLD  = 2;
  localparam int DEF_CNT_W = 8;

  // Slot counter width is max(1, clog2(hold)).
  function automatic int slot_cnt_w(input int hold);
    return (hold <= 2) ? 1 : $clog2(hold);
  endfunction

endpackage

// File: rtl/demux_12_slot_counter.sv
// rtl/demux_12_slot_counter.sv - counts enabled clocks within a lane slot, flags the last one
module slot_counter
  import demux_pkg::*;
#(
  parameter int HOLD = DEF_HOLD
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic slot_end
);

  localparam int CW = slot_cnt_w(HOLD);
  localparam logic [CW-1:0] LAST = CW'(HOLD - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cur;
  logic          step;

  // A clear cycle is itself slot cycle 0, so it is counted as an enabled cycle.
  assign cur      = clear ? '0 : cnt_q;
  assign step     = clear | enable;
  assign slot_end = step && (cur == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (step) begin
      cnt_d = slot_end ? '0 : cur + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/demux_12.sv
// rtl/demux_12.sv - registered 1:2 time-slot demux separating an alternating lane stream
module demux_12
  import demux_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int HOLD  = DEF_HOLD,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sync,
  input  logic             enable,
  input  logic [WIDTH-1:0] data_in,
  output logic             selector,
  output logic [WIDTH-1:0] data_0,
  output logic [WIDTH-1:0] data_1,
  output logic             valid_out,
  output logic [CNT_W-1:0] pair_count
);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shadow_q, shadow_d;
  logic [WIDTH-1:0]   data_0_q, data_0_d;
  logic [WIDTH-1:0]   data_1_q, data_1_d;
  logic               sel_q, sel_d;
  logic               valid_q, valid_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               in_frame;
  logic               slot_end;

  assign in_frame = (state_q == ST_LANE0) || (state_q == ST_LANE1);

  slot_counter #(
    .HOLD(HOLD)
  ) u_slot_counter (
    .clk     (clk),
    .reset   (reset),
    .clear   (sync),
    .enable  (enable && in_frame),
    .slot_end(slot_end)
  );

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    data_0_d = data_0_q;
    data_1_d = data_1_q;
    sel_d    = sel_q;
    valid_d  = 1'b0;
    count_d  = count_q;

    if (sync) begin
      // Realign: the sync cycle is lane-0 slot cycle 0; a partial pair is dropped.
      state_d  = ST_LANE0;
      sel_d    = 1'b0;
      shadow_d = '0;
      if (slot_end) begin
        shadow_d = data_in;
        state_d  = ST_LANE1;
        sel_d    = 1'b1;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
        end
        ST_LANE0: begin
          if (slot_end) begin
            shadow_d = data_in;
            state_d  = ST_LANE1;
            sel_d    = 1'b1;
          end
        end
        ST_LANE1: begin
          if (slot_end) begin
            data_0_d = shadow_q;
            data_1_d = data_in;
            valid_d  = 1'b1;
            count_d  = count_q + 1'b1;
            state_d  = ST_LANE0;
            sel_d    = 1'b0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          sel_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      shadow_q <= '0;
      data_0_q <= '0;
      data_1_q <= '0;
      sel_q    <= 1'b0;
      valid_q  <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      data_0_q <= data_0_d;
      data_1_q <= data_1_d;
      sel_q    <= sel_d;
      valid_q  <= valid_d;
      count_q  <= count_d;
    end
  end

  assign selector   = sel_q;
  assign data_0     = data_0_q;
  assign data_1     = data_1_q;
  assign valid_out  = valid_q;
  assign pair_count = count_q;

endmodule

// File: tb/tb_demux_12.sv
// tb/tb_demux_12.sv - scoreboard bench for demux_12 at HOLD=2/CNT_W=8 and HOLD=1/CNT_W=2
module tb_demux_12;
  import demux_pkg::*;

  localparam int HA = DEF_HOLD;
  localparam int HB = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, sync, enable, da;
  logic [2:0] db;

  logic       sel_a, valid_a, d0_a, d1_a;
  logic [7:0] pc_a;
  logic       sel_b, valid_b;
  logic [2:0] d0_b, d1_b;
  logic [1:0] pc_b;

  demux_12 #(.WIDTH(1), .HOLD(HA), .CNT_W(DEF_CNT_W)) dut_a (
    .clk(clk), .reset(reset), .sync(sync), .enable(enable), .data_in(da),
    .selector(sel_a), .data_0(d0_a), .data_1(d1_a), .valid_out(valid_a), .pair_count(pc_a)
  );

  demux_12 #(.WIDTH(3), .HOLD(HB), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .sync(sync), .enable(enable), .data_in(db),
    .selector(sel_b), .data_0(d0_b), .data_1(d1_b), .valid_out(valid_b), .pair_count(pc_b)
  );

  typedef struct {
    logic [2:0] d0;
    logic [2:0] d1;
    int         cnt;
    int         cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: frame position in enabled clocks, lane = pos / HOLD.
  int         pos [2];
  int         cnt [2];
  bit         act [2];
  bit         selm[2];
  logic [2:0] l0  [2];
  logic [2:0] hd0 [2];
  logic [2:0] hd1 [2];

  function automatic int hold_of(input int k);
    return (k == 0) ? HA : HB;
  endfunction

  function automatic int mod_of(input int k);
    return (k == 0) ? (1 << DEF_CNT_W) : 4;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, got, want, cyc);
    end
  endtask

  always @(posedge clk) begin
    exp_t       e;
    logic [2:0] din;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      din = (k == 0) ? {2'b00, da} : db;
      if (reset) begin
        act[k] = 1'b0; pos[k] = 0; selm[k] = 1'b0; cnt[k] = 0;
        l0[k] = '0; hd0[k] = '0; hd1[k] = '0;
      end else if (sync || (act[k] && enable)) begin
        if (sync) begin
          act[k] = 1'b1;
          pos[k] = 0;
        end
        if (pos[k] == hold_of(k) - 1) l0[k] = din;
        if (pos[k] == 2 * hold_of(k) - 1) begin
          cnt[k] = (cnt[k] + 1) % mod_of(k);
          e.d0 = l0[k]; e.d1 = din; e.cnt = cnt[k]; e.cyc = cyc;
          if (k == 0) qa.push_back(e); else qb.push_back(e);
        end
        pos[k]  = (pos[k] + 1) % (2 * hold_of(k));
        selm[k] = (pos[k] >= hold_of(k));
      end
    end
  end

  task automatic mon(input int k, input logic v, input logic sel,
                     input logic [2:0] d0, input logic [2:0] d1, input logic [7:0] pc);
    exp_t  e;
    bit    have;
    string tag;
    tag  = (k == 0) ? "A" : "B";
    have = (k == 0) ? (qa.size() > 0) : (qb.size() > 0);
    if (have) e = (k == 0) ? qa[0] : qb[0];
    if (v === 1'b1) begin
      if (!have) begin
        n_cmp++; n_bad++;
        $display("FAIL %s_unexpected_strobe: valid_out=1 expected 0 at cycle %0d", tag, cyc);
      end else begin
        if (k == 0) void'(qa.pop_front()); else void'(qb.pop_front());
        chk({tag, "_strobe_cycle"}, cyc, e.cyc);
        chk({tag, "_pair_data_0"}, d0, e.d0);
        chk({tag, "_pair_data_1"}, d1, e.d1);
        chk({tag, "_pair_count"}, pc, e.cnt);
        hd0[k] = e.d0;
        hd1[k] = e.d1;
      end
    end else if (have && e.cyc <= cyc) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_missed_strobe: valid_out=%b expected 1 at cycle %0d", tag, v, cyc);
      if (k == 0) void'(qa.pop_front()); else void'(qb.pop_front());
    end else begin
      chk({tag, "_valid_out"}, v, 0);
    end
    chk({tag, "_selector"}, sel, selm[k]);
    chk({tag, "_data_0_hold"}, d0, hd0[k]);
    chk({tag, "_data_1_hold"}, d1, hd1[k]);
    chk({tag, "_pair_count_hold"}, pc, cnt[k]);
  endtask

  always @(negedge clk) begin
    mon(0, valid_a, sel_a, {2'b00, d0_a}, {2'b00, d1_a}, pc_a);
    mon(1, valid_b, sel_b, d0_b, d1_b, {6'b0, pc_b});
  end

  task automatic drive(input bit s, input bit e, input logic a);
    @(posedge clk);
    #1;
    sync   = s;
    enable = e;
    da     = a;
    db     = 3'($urandom);
  endtask

  initial begin
    reset = 1'b1; sync = 1'b1; enable = 1'b1; da = 1'b1; db = 3'd7;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0; sync = 1'b0; da = 1'b0;
    drive(0, 1, 0);
    drive(0, 1, 1);

    // Basic pair (0,1) starting on sync, then four alternating pairs.
    drive(1, 1, 0); drive(0, 1, 0); drive(0, 1, 1); drive(0, 1, 1);
    for (int p = 0; p < 4; p++) begin
      logic a;
      a = (p % 2 == 1);
      drive(0, 1, a); drive(0, 1, a); drive(0, 1, !a); drive(0, 1, !a);
    end

    // Enable stall for 3 clocks on lane-1 slot cycle 0.
    drive(0, 1, 1); drive(0, 1, 1);
    drive(0, 0, 0); drive(0, 0, 0); drive(0, 0, 0);
    drive(0, 1, 0); drive(0, 1, 0);

    // Mid-frame sync on lane-1 slot cycle 0 drops the partial pair.
    drive(0, 1, 1); drive(0, 1, 1);
    drive(1, 1, 0); drive(0, 1, 0); drive(0, 1, 1); drive(0, 1, 1);

    for (int i = 0; i < 800; i++) begin
      drive($urandom_range(0, 39) == 0, $urandom_range(0, 9) != 0, 1'($urandom));
    end

    repeat (4) drive(0, 0, 0);
    chk("A_pending_pairs", qa.size(), 0);
    chk("B_pending_pairs", qb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
